// File: rtl/alu_seq.sv
// Sequential ALU with a valid/ready handshake on both sides.
// Shifts use a 1-bit-per-cycle shifter; every other op completes in one cycle.
module alu_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       ALUop,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             op_err
);

  localparam logic [3:0] ALU_ADD    = 4'd0;
  localparam logic [3:0] ALU_SUB    = 4'd1;
  localparam logic [3:0] ALU_AND    = 4'd2;
  localparam logic [3:0] ALU_OR     = 4'd3;
  localparam logic [3:0] ALU_XOR    = 4'd4;
  localparam logic [3:0] ALU_SLT    = 4'd5;
  localparam logic [3:0] ALU_SLL    = 4'd6;
  localparam logic [3:0] ALU_SLTU   = 4'd7;
  localparam logic [3:0] ALU_SRL    = 4'd8;
  localparam logic [3:0] ALU_SRA    = 4'd9;
  localparam logic [3:0] ALU_COPY_B = 4'd11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [4:0]       cnt_q, cnt_d;
  logic [3:0]       sop_q, sop_d;

  logic             accept_s;
  logic [WIDTH-1:0] alu_res_s;
  logic             alu_def_s;
  logic             is_shift_s;
  logic [WIDTH-1:0] shifted_s;

  function automatic logic [WIDTH-1:0] shift1(input logic [3:0] kind,
                                              input logic [WIDTH-1:0] v);
    logic [WIDTH-1:0] r;
    case (kind)
      ALU_SLL: r = {v[WIDTH-2:0], 1'b0};
      ALU_SRL: r = {1'b0, v[WIDTH-1:1]};
      ALU_SRA: r = {v[WIDTH-1], v[WIDTH-1:1]};
      default: r = v;
    endcase
    return r;
  endfunction

  assign in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
  assign accept_s  = in_valid && in_ready;
  assign out_valid = (state_q == DONE);
  assign out       = out_q;
  assign op_err    = err_q;
  assign shifted_s = shift1(sop_q, work_q);

  // Single-cycle datapath and opcode classification
  always_comb begin
    alu_res_s  = '0;
    alu_def_s  = 1'b1;
    is_shift_s = 1'b0;
    case (ALUop)
      ALU_ADD:    alu_res_s = A + B;
      ALU_SUB:    alu_res_s = A - B;
      ALU_AND:    alu_res_s = A & B;
      ALU_OR:     alu_res_s = A | B;
      ALU_XOR:    alu_res_s = A ^ B;
      ALU_SLT:    alu_res_s = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
      ALU_SLTU:   alu_res_s = {{(WIDTH-1){1'b0}}, (A < B)};
      ALU_COPY_B: alu_res_s = B;
      ALU_SLL, ALU_SRL, ALU_SRA: is_shift_s = 1'b1;
      default:    alu_def_s = 1'b0;
    endcase
  end

  // Next-state and result-register logic
  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    err_d   = err_q;
    work_d  = work_q;
    cnt_d   = cnt_q;
    sop_d   = sop_q;
    case (state_q)
      IDLE, DONE: begin
        if (accept_s) begin
          // Accepting out of DONE retires the held result on this same edge
          if (is_shift_s) begin
            work_d = A;
            cnt_d  = B[4:0];
            sop_d  = ALUop;
            if (B[4:0] == 5'd0) begin
              out_d   = A;
              err_d   = 1'b0;
              state_d = DONE;
            end else begin
              state_d = SHIFT;
            end
          end else if (alu_def_s) begin
            out_d   = alu_res_s;
            err_d   = 1'b0;
            state_d = DONE;
          end else begin
            out_d   = '0;
            err_d   = 1'b1;
            state_d = DONE;
          end
        end else if ((state_q == DONE) && out_ready) begin
          state_d = IDLE;
        end else begin
          state_d = state_q;
        end
      end
      SHIFT: begin
        work_d = shifted_s;
        cnt_d  = cnt_q - 5'd1;
        if (cnt_q == 5'd1) begin
          out_d   = shifted_s;
          err_d   = 1'b0;
          state_d = DONE;
        end else begin
          state_d = SHIFT;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      out_q   <= '0;
      err_q   <= 1'b0;
      work_q  <= '0;
      cnt_q   <= 5'd0;
      sop_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      err_q   <= err_d;
      work_q  <= work_d;
      cnt_q   <= cnt_d;
      sop_q   <= sop_d;
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: stimulus pushes expected results, a monitor
// pops and compares on every output handshake.
module tb_alu_seq;

  localparam logic [3:0] ALU_ADD    = 4'd0;
  localparam logic [3:0] ALU_SUB    = 4'd1;
  localparam logic [3:0] ALU_AND    = 4'd2;
  localparam logic [3:0] ALU_OR     = 4'd3;
  localparam logic [3:0] ALU_XOR    = 4'd4;
  localparam logic [3:0] ALU_SLT    = 4'd5;
  localparam logic [3:0] ALU_SLL    = 4'd6;
  localparam logic [3:0] ALU_SLTU   = 4'd7;
  localparam logic [3:0] ALU_SRL    = 4'd8;
  localparam logic [3:0] ALU_SRA    = 4'd9;
  localparam logic [3:0] ALU_COPY_B = 4'd11;
  localparam logic [3:0] ALU_XXX    = 4'd15;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  ALUop;
  logic [31:0] A;
  logic [31:0] B;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out;
  logic        op_err;

  typedef struct packed {
    logic [31:0] o;
    logic        e;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   valid_seen;

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(32)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .ALUop    (ALUop),
    .A        (A),
    .B        (B),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out      (out),
    .op_err   (op_err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Present a request and hold it until accepted; optionally record the expected result
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] eo, input logic ee, input bit push);
    int budget;
    budget   = 0;
    in_valid = 1'b1;
    ALUop    = op;
    A        = a;
    B        = b;
    #1;
    while (!in_ready && budget < 100) begin
      budget++;
      @(negedge clk);
    end
    if (!in_ready) begin
      n_checks++;
      n_errors++;
      $display("FAIL accept_timeout: in_ready=0 after %0d cycles, expected 1", budget);
    end else if (push) begin
      sb_q.push_back(exp_t'{o: eo, e: ee});
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    ALUop    = ALU_ADD;
    A        = 32'hDEAD_BEEF;
    B        = 32'hCAFE_F00D;
  endtask

  // Scoreboard monitor: compare every retired result against the queue head
  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_result: got out=%h op_err=%b, expected no result", out, op_err);
      end else begin
        e = sb_q.pop_front();
        check("result_out", out, e.o);
        check("result_op_err", {31'd0, op_err}, {31'd0, e.e});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    ALUop     = ALU_ADD;
    A         = 32'd0;
    B         = 32'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_in_ready", {31'd0, in_ready}, 32'd1);
    check("reset_out_valid", {31'd0, out_valid}, 32'd0);
    check("reset_out", out, 32'd0);
    check("reset_op_err", {31'd0, op_err}, 32'd0);
    #2 rst_n = 1'b1;

    // ADD wraps; one-cycle latency, then back to IDLE
    issue(ALU_ADD, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 1'b1);
    @(negedge clk);
    check("add_latency_valid", {31'd0, out_valid}, 32'd1);
    @(negedge clk);
    check("add_then_idle_valid", {31'd0, out_valid}, 32'd0);
    check("add_then_idle_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;

    issue(ALU_SLT,  32'hFFFF_FFFE, 32'd1, 32'd1, 1'b0, 1'b1);
    issue(ALU_SLTU, 32'hFFFF_FFFE, 32'd1, 32'd0, 1'b0, 1'b1);
    repeat (2) @(posedge clk); #1;

    // SRA by 4: four busy cycles, result in the fifth
    issue(ALU_SRA, 32'h8000_0000, 32'h0000_0024, 32'hF800_0000, 1'b0, 1'b1);
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      check("sra_busy_in_ready", {31'd0, in_ready}, 32'd0);
    end
    @(negedge clk);
    check("sra_valid_cycle5", {31'd0, out_valid}, 32'd1);
    @(posedge clk); #1;

    // SRL with a request waved at the block while it is shifting
    issue(ALU_SRL, 32'h8000_0000, 32'h0000_0024, 32'h0800_0000, 1'b0, 1'b1);
    in_valid = 1'b1;
    ALUop    = ALU_XOR;
    A        = 32'h1111_1111;
    B        = 32'h0000_0001;
    repeat (2) @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (6) @(posedge clk); #1;

    // Shift amount zero with upper B bits set: result is A after one cycle
    issue(ALU_SLL, 32'h1234_5678, 32'hFFFF_FFE0, 32'h1234_5678, 1'b0, 1'b1);
    @(negedge clk);
    check("shamt0_latency_valid", {31'd0, out_valid}, 32'd1);
    @(posedge clk); #1;

    // Consumer stalls for three cycles, then retires while a new op is accepted
    out_ready = 1'b0;
    issue(ALU_ADD, 32'd5, 32'd7, 32'd12, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_out_valid", {31'd0, out_valid}, 32'd1);
      check("stall_out", out, 32'd12);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    issue(ALU_XOR, 32'hFF00_FF00, 32'h0FF0_0FF0, 32'hF0F0_F0F0, 1'b0, 1'b1);
    @(negedge clk);
    check("no_bubble_valid", {31'd0, out_valid}, 32'd1);
    @(posedge clk); #1;

    issue(ALU_XXX,    32'h0000_1234, 32'h0000_5678, 32'd0,         1'b1, 1'b1);
    issue(ALU_AND,    32'h0000_F0F0, 32'h0000_0FF0, 32'h0000_00F0, 1'b0, 1'b1);
    issue(ALU_SUB,    32'd0,         32'd1,         32'hFFFF_FFFF, 1'b0, 1'b1);
    issue(ALU_COPY_B, 32'hAAAA_AAAA, 32'h5555_5555, 32'h5555_5555, 1'b0, 1'b1);
    issue(ALU_OR,     32'hA000_0000, 32'h0000_000A, 32'hA000_000A, 1'b0, 1'b1);
    issue(4'd12,      32'd1,         32'd1,         32'd0,         1'b1, 1'b1);
    repeat (2) @(posedge clk); #1;

    // Reset in the middle of a long shift; the aborted result must never appear
    issue(ALU_SLL, 32'h0000_0001, 32'd31, 32'd0, 1'b0, 1'b0);
    repeat (2) @(posedge clk); #1;
    rst_n = 1'b0;
    @(negedge clk);
    check("midreset_out_valid", {31'd0, out_valid}, 32'd0);
    check("midreset_out", out, 32'd0);
    check("midreset_op_err", {31'd0, op_err}, 32'd0);
    check("midreset_in_ready", {31'd0, in_ready}, 32'd1);
    #2 rst_n = 1'b1;
    issue(ALU_ADD, 32'd2, 32'd3, 32'd5, 1'b0, 1'b1);
    @(negedge clk);
    check("post_reset_accept_valid", {31'd0, out_valid}, 32'd1);
    valid_seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) valid_seen++;
    end
    check("aborted_never_valid", 32'(valid_seen), 32'd0);

    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
